// File: rtl/preifu_bpu_pkg.sv
// Package for the pre-IF stage with branch prediction.
// Holds shared constants, the BTB entry layout, the redirect-cause
// encoding and the 2-bit saturating counter step function.
package preifu_pkg;

  localparam int PC_W = 32;

  // The tag field is stored at a fixed maximum width, zero-extended
  // from BTB_TAG_W, so the packed struct does not depend on module
  // parameters.
  localparam int TAG_MAX_W = 30;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                 v;
    logic [TAG_MAX_W-1:0] tag;
    logic [PC_W-1:0]      tgt;
    logic [1:0]           ctr;
  } btb_entry_t;

  typedef enum logic [2:0] {
    CAUSE_HOLD,
    CAUSE_REFETCH,
    CAUSE_TLBR,
    CAUSE_EXCP,
    CAUSE_ERTN,
    CAUSE_BR,
    CAUSE_PRED,
    CAUSE_SEQ
  } redirect_cause_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != CTR_ST) res = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) res = ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/preifu_bpu_if.sv
// Handshake between the pre-IF stage (master) and the IF stage (slave).
//   preifu_valid_o : pc/prediction valid toward IF
//   pc_o           : fetch PC
//   pred_taken_o   : BTB predicts taken for pc_o
//   pred_target_o  : predicted target (0 when not taken)
//   ifu_allowin_i  : IF stage can accept
interface preifu_bpu_if;
  import preifu_pkg::*;

  logic            preifu_valid_o;
  logic [PC_W-1:0] pc_o;
  logic            pred_taken_o;
  logic [PC_W-1:0] pred_target_o;
  logic            ifu_allowin_i;

  modport master (
    output preifu_valid_o, pc_o, pred_taken_o, pred_target_o,
    input  ifu_allowin_i
  );

  modport slave (
    input  preifu_valid_o, pc_o, pred_taken_o, pred_target_o,
    output ifu_allowin_i
  );
endinterface

// File: rtl/preifu_bpu_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
//   clk, rst       : clock, synchronous active-high reset (invalidates all)
//   lookup_pc      : combinational lookup address
//   lookup_taken   : entry hits and counter says taken
//   lookup_tgt     : stored target of the indexed entry
//   upd_*          : one resolved branch per cycle, written at the clock edge
module preifu_btb
  import preifu_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int BTB_TAG_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [PC_W-1:0] lookup_tgt,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t entries [BTB_ENTRIES];

  logic [IDX_W-1:0]     lk_idx, up_idx;
  logic [TAG_MAX_W-1:0] lk_tag, up_tag;
  btb_entry_t           lk_e, up_e;
  logic                 up_hit;
  logic                 unused_pc_bits;

  // Only the index and tag slices of the PCs matter; the rest is folded
  // into one signal so the unused bits are explicit.
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];

  // Tags are zero-extended to the stored width so a full-field compare works.
  always_comb begin
    lk_tag = '0;
    up_tag = '0;
    lk_tag[BTB_TAG_W-1:0] = lookup_pc[IDX_W+2 +: BTB_TAG_W];
    up_tag[BTB_TAG_W-1:0] = upd_pc[IDX_W+2 +: BTB_TAG_W];
  end

  assign lk_e         = entries[lk_idx];
  assign up_e         = entries[up_idx];
  assign up_hit       = up_e.v && (up_e.tag == up_tag);
  assign lookup_taken = lk_e.v && (lk_e.tag == lk_tag) && lk_e.ctr[1];
  assign lookup_tgt   = lk_e.tgt;

  // Training: a hit steps the counter (and refreshes the target when taken);
  // a taken miss replaces the entry starting at weakly-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        entries[i].v   <= 1'b0;
        entries[i].tag <= '0;
        entries[i].tgt <= '0;
        entries[i].ctr <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        entries[up_idx].ctr <= ctr_next(up_e.ctr, upd_taken);
        if (upd_taken) entries[up_idx].tgt <= upd_target;
      end else if (upd_taken) begin
        entries[up_idx] <= '{v: 1'b1, tag: up_tag, tgt: upd_target, ctr: CTR_WT};
      end
    end
  end

endmodule

// File: rtl/preifu_bpu.sv
// Pre-IF stage: holds the fetch PC, picks the next PC by fixed redirect
// priority (refetch > tlbr > excp > ertn > br_redirect > BTB > sequential)
// and presents {pc, prediction} to IF over a valid/allowin handshake.
//   clk, rst          : clock, synchronous active-high reset
//   *_i redirects     : redirect requests with their target PCs
//   upd_*_i           : BTB training from the branch-resolution stage
//   ifu               : master side of the IF handshake
module preifu_bpu
  import preifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  parameter int          INST_BYTES  = 4,
  parameter int          BTB_ENTRIES = 16,
  parameter int          BTB_TAG_W   = 8,
  parameter int          PREDICT_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refetch_i,
  input  logic [31:0] refetch_pc_i,
  input  logic        excp_tlbr_i,
  input  logic [31:0] csr_tlbrentry_i,
  input  logic        excp_i,
  input  logic [31:0] csr_eentry_i,
  input  logic        ertn_i,
  input  logic [31:0] csr_era_i,
  input  logic        br_redirect_i,
  input  logic [31:0] br_target_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  preifu_bpu_if.master ifu
);

  logic [31:0]     pc_q, next_pc, btb_tgt, pred_target;
  logic            valid_q, flush, adv, btb_taken, pred_taken;
  redirect_cause_e cause;

  preifu_btb #(
    .BTB_ENTRIES(BTB_ENTRIES),
    .BTB_TAG_W  (BTB_TAG_W)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_q),
    .lookup_taken(btb_taken),
    .lookup_tgt  (btb_tgt),
    .upd_valid   (upd_valid_i),
    .upd_pc      (upd_pc_i),
    .upd_taken   (upd_taken_i),
    .upd_target  (upd_target_i)
  );

  assign pred_taken  = (PREDICT_EN != 0) && btb_taken;
  assign pred_target = pred_taken ? btb_tgt : 32'h0;

  // Next-PC priority mux. While not yet valid (first cycle after reset) the
  // PC is held so RESET_PC itself is the first fetch address presented.
  always_comb begin
    cause   = CAUSE_HOLD;
    next_pc = pc_q;
    if (refetch_i) begin
      cause   = CAUSE_REFETCH;
      next_pc = refetch_pc_i;
    end else if (excp_tlbr_i) begin
      cause   = CAUSE_TLBR;
      next_pc = csr_tlbrentry_i;
    end else if (excp_i) begin
      cause   = CAUSE_EXCP;
      next_pc = csr_eentry_i;
    end else if (ertn_i) begin
      cause   = CAUSE_ERTN;
      next_pc = csr_era_i;
    end else if (br_redirect_i) begin
      cause   = CAUSE_BR;
      next_pc = br_target_i;
    end else if (!valid_q) begin
      cause   = CAUSE_HOLD;
      next_pc = pc_q;
    end else if (pred_taken) begin
      cause   = CAUSE_PRED;
      next_pc = pred_target;
    end else begin
      cause   = CAUSE_SEQ;
      next_pc = pc_q + 32'(INST_BYTES);
    end
  end

  assign flush = cause inside {CAUSE_REFETCH, CAUSE_TLBR, CAUSE_EXCP, CAUSE_ERTN, CAUSE_BR};
  assign adv   = !valid_q || flush || ifu.ifu_allowin_i;

  // PC/valid register: redirects always load, otherwise advance only when IF accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (adv) begin
      pc_q    <= next_pc;
      valid_q <= 1'b1;
    end
  end

  assign ifu.preifu_valid_o = valid_q && !flush;
  assign ifu.pc_o           = pc_q;
  assign ifu.pred_taken_o   = pred_taken;
  assign ifu.pred_target_o  = pred_target;

endmodule

// File: tb/tb_preifu_bpu.sv
// Directed self-checking bench for preifu_bpu. dut0 uses default
// parameters; dut1 shares all inputs but has PREDICT_EN=0.
module tb_preifu_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        refetch_i, excp_tlbr_i, excp_i, ertn_i, br_redirect_i;
  logic [31:0] refetch_pc_i, csr_tlbrentry_i, csr_eentry_i, csr_era_i, br_target_i;
  logic        upd_valid_i, upd_taken_i;
  logic [31:0] upd_pc_i, upd_target_i;
  int          n_cmp = 0;
  int          n_bad = 0;

  preifu_bpu_if ifu0 ();
  preifu_bpu_if ifu1 ();

  always #5 clk = ~clk;

  preifu_bpu dut0 (
    .clk(clk), .rst(rst),
    .refetch_i(refetch_i), .refetch_pc_i(refetch_pc_i),
    .excp_tlbr_i(excp_tlbr_i), .csr_tlbrentry_i(csr_tlbrentry_i),
    .excp_i(excp_i), .csr_eentry_i(csr_eentry_i),
    .ertn_i(ertn_i), .csr_era_i(csr_era_i),
    .br_redirect_i(br_redirect_i), .br_target_i(br_target_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .ifu(ifu0)
  );

  preifu_bpu #(.PREDICT_EN(0)) dut1 (
    .clk(clk), .rst(rst),
    .refetch_i(refetch_i), .refetch_pc_i(refetch_pc_i),
    .excp_tlbr_i(excp_tlbr_i), .csr_tlbrentry_i(csr_tlbrentry_i),
    .excp_i(excp_i), .csr_eentry_i(csr_eentry_i),
    .ertn_i(ertn_i), .csr_era_i(csr_era_i),
    .br_redirect_i(br_redirect_i), .br_target_i(br_target_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .ifu(ifu1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_allowin(input logic a);
    ifu0.ifu_allowin_i = a;
    ifu1.ifu_allowin_i = a;
  endtask

  task automatic clear_inputs();
    refetch_i = 0; excp_tlbr_i = 0; excp_i = 0; ertn_i = 0; br_redirect_i = 0;
    refetch_pc_i = 0; csr_tlbrentry_i = 0; csr_eentry_i = 0; csr_era_i = 0; br_target_i = 0;
    upd_valid_i = 0; upd_taken_i = 0; upd_pc_i = 0; upd_target_i = 0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    br_redirect_i = 1; br_target_i = t;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid_i = 1; upd_pc_i = pc; upd_taken_i = taken; upd_target_i = tgt;
  endtask

  task automatic test_reset();
    rst = 1; set_allowin(1); clear_inputs();
    tick(); tick();
    n_cmp++; if (ifu0.pc_o !== 32'h1c000000) begin n_bad++; $display("[TB] FAIL reset_pc: got %h want %h", ifu0.pc_o, 32'h1c000000); end
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", ifu0.preifu_valid_o); end
    n_cmp++; if (ifu0.pred_taken_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pred_taken: got %b want 0", ifu0.pred_taken_o); end
    n_cmp++; if (ifu0.pred_target_o !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_pred_target: got %h want 0", ifu0.pred_target_o); end
    rst = 0; #1;
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL release_valid: got %b want 0", ifu0.preifu_valid_o); end
    tick();
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b1) begin n_bad++; $display("[TB] FAIL first_valid: got %b want 1", ifu0.preifu_valid_o); end
    n_cmp++; if (ifu0.pc_o !== 32'h1c000000) begin n_bad++; $display("[TB] FAIL first_pc: got %h want %h", ifu0.pc_o, 32'h1c000000); end
    tick();
    n_cmp++; if (ifu0.pc_o !== 32'h1c000004) begin n_bad++; $display("[TB] FAIL seq_pc1: got %h want %h", ifu0.pc_o, 32'h1c000004); end
    tick();
    n_cmp++; if (ifu0.pc_o !== 32'h1c000008) begin n_bad++; $display("[TB] FAIL seq_pc2: got %h want %h", ifu0.pc_o, 32'h1c000008); end
  endtask

  task automatic test_priority();
    excp_i = 1; csr_eentry_i = 32'h1c001000;
    ertn_i = 1; csr_era_i = 32'h1c002000;
    redirect_to(32'h1c003000); #1;
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL excp_flush_valid: got %b want 0", ifu0.preifu_valid_o); end
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pc_o !== 32'h1c001000) begin n_bad++; $display("[TB] FAIL excp_pc: got %h want %h", ifu0.pc_o, 32'h1c001000); end
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b1) begin n_bad++; $display("[TB] FAIL excp_valid: got %b want 1", ifu0.preifu_valid_o); end
    refetch_i = 1; refetch_pc_i = 32'h1c000040;
    excp_tlbr_i = 1; csr_tlbrentry_i = 32'h1c00e000;
    excp_i = 1; csr_eentry_i = 32'h1c001000;
    ertn_i = 1; csr_era_i = 32'h1c002000;
    redirect_to(32'h1c003000); #1;
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL refetch_flush_valid: got %b want 0", ifu0.preifu_valid_o); end
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pc_o !== 32'h1c000040) begin n_bad++; $display("[TB] FAIL refetch_pc: got %h want %h", ifu0.pc_o, 32'h1c000040); end
    excp_tlbr_i = 1; csr_tlbrentry_i = 32'h1c00e000;
    excp_i = 1; csr_eentry_i = 32'h1c001000;
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pc_o !== 32'h1c00e000) begin n_bad++; $display("[TB] FAIL tlbr_pc: got %h want %h", ifu0.pc_o, 32'h1c00e000); end
    ertn_i = 1; csr_era_i = 32'h1c002000;
    redirect_to(32'h1c003000);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pc_o !== 32'h1c002000) begin n_bad++; $display("[TB] FAIL ertn_pc: got %h want %h", ifu0.pc_o, 32'h1c002000); end
  endtask

  task automatic test_alloc();
    train(32'h1c000010, 1, 32'h1c000100);
    redirect_to(32'h1c000010);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pc_o !== 32'h1c000010) begin n_bad++; $display("[TB] FAIL alloc_pc: got %h want %h", ifu0.pc_o, 32'h1c000010); end
    n_cmp++; if (ifu0.pred_taken_o !== 1'b1) begin n_bad++; $display("[TB] FAIL alloc_pred: got %b want 1", ifu0.pred_taken_o); end
    n_cmp++; if (ifu0.pred_target_o !== 32'h1c000100) begin n_bad++; $display("[TB] FAIL alloc_target: got %h want %h", ifu0.pred_target_o, 32'h1c000100); end
    n_cmp++; if (ifu1.pred_taken_o !== 1'b0) begin n_bad++; $display("[TB] FAIL nopred_taken: got %b want 0", ifu1.pred_taken_o); end
    n_cmp++; if (ifu1.pred_target_o !== 32'h0) begin n_bad++; $display("[TB] FAIL nopred_target: got %h want 0", ifu1.pred_target_o); end
    tick();
    n_cmp++; if (ifu0.pc_o !== 32'h1c000100) begin n_bad++; $display("[TB] FAIL pred_follow_pc: got %h want %h", ifu0.pc_o, 32'h1c000100); end
    n_cmp++; if (ifu1.pc_o !== 32'h1c000014) begin n_bad++; $display("[TB] FAIL nopred_seq_pc: got %h want %h", ifu1.pc_o, 32'h1c000014); end
  endtask

  task automatic test_counters();
    train(32'h1c000010, 1, 32'h1c000100);
    tick(); tick();
    clear_inputs();
    train(32'h1c000010, 0, 32'h0);
    redirect_to(32'h1c000010);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pred_taken_o !== 1'b1) begin n_bad++; $display("[TB] FAIL ctr_sat_pred: got %b want 1", ifu0.pred_taken_o); end
    train(32'h1c000030, 0, 32'h1c000400);
    redirect_to(32'h1c000030);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pred_taken_o !== 1'b0) begin n_bad++; $display("[TB] FAIL nt_miss_noalloc: got %b want 0", ifu0.pred_taken_o); end
  endtask

  task automatic test_same_cycle();
    redirect_to(32'h1c000010);
    tick(); clear_inputs();
    train(32'h1c000010, 0, 32'h0);
    redirect_to(32'h1c000010); #1;
    n_cmp++; if (ifu0.pred_taken_o !== 1'b1) begin n_bad++; $display("[TB] FAIL same_cycle_old: got %b want 1", ifu0.pred_taken_o); end
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pc_o !== 32'h1c000010) begin n_bad++; $display("[TB] FAIL same_cycle_pc: got %h want %h", ifu0.pc_o, 32'h1c000010); end
    n_cmp++; if (ifu0.pred_taken_o !== 1'b0) begin n_bad++; $display("[TB] FAIL same_cycle_new: got %b want 0", ifu0.pred_taken_o); end
    n_cmp++; if (ifu0.pred_target_o !== 32'h0) begin n_bad++; $display("[TB] FAIL same_cycle_target: got %h want 0", ifu0.pred_target_o); end
  endtask

  task automatic test_alias();
    train(32'h1c000010, 1, 32'h1c000100);
    redirect_to(32'h1c000050);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pred_taken_o !== 1'b0) begin n_bad++; $display("[TB] FAIL alias_pred: got %b want 0", ifu0.pred_taken_o); end
    n_cmp++; if (ifu0.pred_target_o !== 32'h0) begin n_bad++; $display("[TB] FAIL alias_target: got %h want 0", ifu0.pred_target_o); end
    tick();
    n_cmp++; if (ifu0.pc_o !== 32'h1c000054) begin n_bad++; $display("[TB] FAIL alias_seq_pc: got %h want %h", ifu0.pc_o, 32'h1c000054); end
    redirect_to(32'h1c000010);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pred_taken_o !== 1'b1) begin n_bad++; $display("[TB] FAIL retrain_pred: got %b want 1", ifu0.pred_taken_o); end
    n_cmp++; if (ifu0.pred_target_o !== 32'h1c000100) begin n_bad++; $display("[TB] FAIL retrain_target: got %h want %h", ifu0.pred_target_o, 32'h1c000100); end
  endtask

  task automatic test_stall();
    set_allowin(0); #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (ifu0.pc_o !== 32'h1c000010 || ifu0.pred_taken_o !== 1'b1 || ifu0.pred_target_o !== 32'h1c000100 || ifu0.preifu_valid_o !== 1'b1) begin
        n_bad++; $display("[TB] FAIL stall_hold[%0d]: got pc=%h pt=%b tgt=%h v=%b want pc=1c000010 pt=1 tgt=1c000100 v=1", i, ifu0.pc_o, ifu0.pred_taken_o, ifu0.pred_target_o, ifu0.preifu_valid_o);
      end
      if (i < 3) tick();
    end
    redirect_to(32'h1c000200); #1;
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_br_flush: got %b want 0", ifu0.preifu_valid_o); end
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pc_o !== 32'h1c000200) begin n_bad++; $display("[TB] FAIL stall_br_pc: got %h want %h", ifu0.pc_o, 32'h1c000200); end
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_br_valid: got %b want 1", ifu0.preifu_valid_o); end
    set_allowin(1);
  endtask

  task automatic test_wrap();
    redirect_to(32'hfffffffc);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pc_o !== 32'hfffffffc) begin n_bad++; $display("[TB] FAIL wrap_start: got %h want fffffffc", ifu0.pc_o); end
    tick();
    n_cmp++; if (ifu0.pc_o !== 32'h00000000) begin n_bad++; $display("[TB] FAIL wrap_pc: got %h want 00000000", ifu0.pc_o); end
  endtask

  task automatic test_reset_mid();
    rst = 1;
    train(32'h1c000020, 1, 32'h1c000300);
    tick(); clear_inputs();
    n_cmp++; if (ifu0.preifu_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_valid: got %b want 0", ifu0.preifu_valid_o); end
    rst = 0;
    tick();
    n_cmp++; if (ifu0.pc_o !== 32'h1c000000) begin n_bad++; $display("[TB] FAIL midrst_pc: got %h want %h", ifu0.pc_o, 32'h1c000000); end
    redirect_to(32'h1c000010);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pred_taken_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_invalid_a: got %b want 0", ifu0.pred_taken_o); end
    redirect_to(32'h1c000020);
    tick(); clear_inputs(); #1;
    n_cmp++; if (ifu0.pred_taken_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_invalid_b: got %b want 0", ifu0.pred_taken_o); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_alloc();
    test_counters();
    test_same_cycle();
    test_alias();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
